// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decode helpers.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFix,
      StDone
   } state_t;

   function automatic logic op_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return !((op == OP_MULT) || (op == OP_MULTU));
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; passes data through when en_i is low.
module muldiv_negate #(
   parameter int unsigned Width = 32
) (
   input  logic             en_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o
);

   always_comb begin
      data_o = en_i ? (~data_i + Width'(1)) : data_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency sequential multiply/divide engine: operand magnitudes are
// processed with shift-add or restoring division, then sign-corrected.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               b_zero_q, b_zero_d;
   logic [WIDTH-1:0]   orig_a_q, orig_a_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quo_fixed, rem_fixed;

   assign a_neg = op_signed(op) & op_a[WIDTH-1];
   assign b_neg = op_signed(op) & op_b[WIDTH-1];

   muldiv_negate #(.Width(WIDTH)) u_abs_a (
      .en_i   (a_neg),
      .data_i (op_a),
      .data_o (a_mag)
   );

   muldiv_negate #(.Width(WIDTH)) u_abs_b (
      .en_i   (b_neg),
      .data_i (op_b),
      .data_o (b_mag)
   );

   muldiv_negate #(.Width(2 * WIDTH)) u_fix_prod (
      .en_i   (neg_res_q),
      .data_i (acc_q),
      .data_o (prod_fixed)
   );

   muldiv_negate #(.Width(WIDTH)) u_fix_quo (
      .en_i   (neg_res_q),
      .data_i (acc_q[WIDTH-1:0]),
      .data_o (quo_fixed)
   );

   muldiv_negate #(.Width(WIDTH)) u_fix_rem (
      .en_i   (neg_rem_q),
      .data_i (acc_q[2*WIDTH-1:WIDTH]),
      .data_o (rem_fixed)
   );

   // Multiply step: add multiplicand to the upper half when the low bit is set,
   // keep the carry and shift the whole accumulator right by one.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Divide step: the shifted remainder can reach 2*divisor-1, so it is held
   // at WIDTH+1 bits for the trial subtraction.
   logic [WIDTH:0]     rem_sh, trial;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd_q};
      if (trial[WIDTH]) begin
         div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_zero_d  = b_zero_q;
      orig_a_d  = orig_a_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;

      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               state_d   = StRun;
               cnt_d     = '0;
               is_div_d  = op_is_div(op);
               opnd_d    = op_is_div(op) ? b_mag : a_mag;
               acc_d     = {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               b_zero_d  = (op_b == '0);
               orig_a_d  = op_a;
            end
         end
         StRun: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               state_d = StDone;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fixed;
                  dbz_d        = 1'b0;
               end else if (b_zero_q) begin
                  lo_d  = '1;
                  hi_d  = orig_a_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d  = quo_fixed;
                  hi_d  = rem_fixed;
                  dbz_d = 1'b0;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         orig_a_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_zero_q  <= b_zero_d;
         orig_a_q  <= orig_a_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = (state_q == StRun) || (state_q == StFix);
   assign done        = (state_q == StDone);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule
